// File: rtl/intr_ctrl.sv
// Priority interrupt controller: latches rising edges from NSRC peripheral
// sources, masks them, and presents the highest-priority eligible source to
// the CPU on interrupt/irq. The request is held until ack, and no further
// request is made until the CPU signals end-of-interrupt (eoi).
//
// CPU handshake: interrupt acts as "valid" and ack as "ready". Once interrupt
// is raised, irq stays stable and interrupt stays high until a cycle with
// ack=1. The transfer completes on that edge: interrupt drops and the source
// is cleared. ack seen while interrupt=0 carries no meaning and is ignored.
// eoi only has an effect while in_service=1.
module intr_ctrl #(
  parameter int unsigned NSRC       = 8,
  parameter logic [7:0]  MASK_RESET = 8'h00
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            cfg_we,
  input  logic [NSRC-1:0] cfg_wdata,
  input  logic            ack,
  input  logic            eoi,
  output logic            interrupt,
  output logic [2:0]      irq,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask,
  output logic            in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] edges;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] pending_d;
  logic [2:0]      winner;
  logic            interrupt_d;
  logic [2:0]      irq_d;
  logic            in_service_d;
  logic            take;

  // Rising-edge detect and eligibility of latched requests.
  always_comb begin
    edges    = src & ~src_q;
    eligible = pending & ~mask;
  end

  // Lowest set eligible bit wins; scanning downwards leaves the lowest index.
  always_comb begin
    winner = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // Next-state and registered-output values for the request FSM.
  always_comb begin
    state_d      = state;
    interrupt_d  = interrupt;
    irq_d        = irq;
    in_service_d = in_service;
    take         = 1'b0;
    case (state)
      IDLE: begin
        if (eligible != '0) begin
          irq_d       = winner;
          interrupt_d = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        // eoi during REQ is meaningless; only ack moves the FSM on.
        if (ack) begin
          take         = 1'b1;
          interrupt_d  = 1'b0;
          in_service_d = 1'b1;
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        interrupt_d  = 1'b0;
        in_service_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // Pending update: acknowledged source clears, but a fresh edge always wins.
  always_comb begin
    clr = '0;
    if (take) clr[irq] = 1'b1;
    pending_d = (pending & ~clr) | edges;
  end

  // State, outputs, mask and edge history registers.
  always_ff @(posedge clock) begin
    src_q <= src;
    if (reset) begin
      state      <= IDLE;
      interrupt  <= 1'b0;
      irq        <= 3'd0;
      in_service <= 1'b0;
      pending    <= '0;
      mask       <= MASK_RESET[NSRC-1:0];
    end else begin
      state      <= state_d;
      interrupt  <= interrupt_d;
      irq        <= irq_d;
      in_service <= in_service_d;
      pending    <= pending_d;
      if (cfg_we) mask <= cfg_wdata;
    end
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Priority interrupt controller that drives the CPU's `interrupt`/`irq[2:0]` request inputs; this block is the requesting end of that interface.
- Latches rising edges from 8 peripheral sources into a pending register and applies a software-written mask.
- Presents the highest-priority unmasked request as a 3-bit vector and holds it until the CPU acknowledges.
- Blocks further requests until the CPU signals end-of-interrupt, its IRET.

Parameters:
- NSRC, 8, number of interrupt sources; fixed at 8 so the vector fits `irq[2:0]`.
- MASK_RESET, 8'h00, mask register value after reset (1 = source disabled).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- src  in  8  interrupt source levels; a rising edge requests.
- cfg_we  in  1  mask write strobe.
- cfg_wdata  in  8  new mask value, written when cfg_we=1.
- ack  in  1  CPU has taken the request (one-cycle pulse).
- eoi  in  1  CPU executed IRET (one-cycle pulse).
- interrupt  out  1  request to CPU.
- irq  out  3  vector of the presented source.
- pending  out  8  pending register.
- mask  out  8  mask register.
- in_service  out  1  high while in state SERVICE.

Behaviour:
- Reset, synchronous and active-high:
  - interrupt=0, irq=0, pending=0, mask=MASK_RESET, in_service=0, state=IDLE.
  - src_q<=src, so a source already high at reset release is not an edge.
  - Reset asserted mid-operation drops interrupt on that same edge and discards all pending state.
- Edge detect:
  - Each posedge: src_q<=src.
  - Edge on source i at posedge k when src[i]=1 and src_q[i]=0; then pending[i]<=1 at edge k.
  - Levels held high do not re-request.
- Masking:
  - A masked source still latches pending but is not eligible.
  - eligible = pending & ~mask.
  - cfg_we writes mask at the posedge; the new mask affects eligibility from the next cycle.
- Priority: src[0] highest, src[7] lowest; irq = index of the lowest set bit of eligible.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if eligible!=0, then at next posedge irq<=winner, interrupt<=1, state<=REQ.
  - REQ:
    - interrupt held 1 and irq held stable until ack.
    - On ack: pending[irq]<=0, interrupt<=0, in_service<=1, state<=SERVICE.
    - A higher-priority edge arriving in REQ does not change irq (no preemption).
    - A mask write in REQ does not retract the request.
  - SERVICE:
    - No request is made.
    - On eoi: in_service<=0, state<=IDLE.
    - Re-arbitration happens in IDLE on the following cycle.
- Latency:
  - Edge sampled at posedge k, so interrupt=1 after posedge k+1.
  - After eoi at posedge m, the next request has interrupt=1 after posedge m+1 (earliest).
- Simultaneous and illegal events:
  - New edge on source i in the same cycle ack clears pending[i]: set wins, and pending[i] stays 1.
  - ack outside REQ: ignored.
  - eoi outside SERVICE: ignored.
  - ack and eoi together in REQ: ack processed, eoi ignored.
  - cfg_we together with an edge: both take effect.
- Outputs are registered, with no combinational path from inputs to interrupt or irq.

Test Plan:
- Single request:
  - src[5] 0→1 sampled at posedge 3, mask=0.
  - Expect pending=8'h20 after posedge 3; interrupt=1, irq=5 after posedge 4.
  - ack at posedge 6 gives interrupt=0, pending=0, in_service=1.
  - eoi at posedge 9 gives in_service=0.
- Priority and nesting:
  - src[6] and src[2] rise in the same cycle.
  - Expect irq=2 first.
  - After ack and eoi, expect irq=6 with interrupt=1 one cycle after the eoi edge.
- Masking:
  - Write mask=8'h08, then pulse src[3].
  - Expect pending=8'h08 with interrupt staying 0.
  - Write mask=0; expect interrupt=1, irq=3 one cycle after the write takes effect.
- No preemption:
  - Hold REQ with irq=4 and no ack; src[0] rises.
  - Expect irq stays 4 and pending=8'h11.
  - ack then eoi gives irq=0.
- Set-wins collision:
  - In REQ with irq=1, assert ack in the same cycle src[1] produces a new edge.
  - Expect pending[1]=1 after the edge.
  - After eoi, expect interrupt=1, irq=1 again.
- Reset mid-operation and level suppression:
  - Assert reset while in REQ with src[7] held high.
  - Expect interrupt=0, pending=0, mask=MASK_RESET after the reset edge.
  - After release, with src[7] still high, expect no request.
  - A 1→0→1 toggle on src[7] then requests irq=7.
